// File: rtl/scroll_pkg.sv
// Shared definitions for the scroll controller: state encoding and default sizes.
package scroll_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam int NUM_MSG_DEF    = 4;
  localparam int MSG_LEN_DEF    = 16;
  localparam int SPEED_LVLS_DEF = 4;

endpackage

// File: rtl/scroll_rate_div.sv
// Tick divider and speed level register; level k advances once every 2^(SPEED_LVLS-1-k) ticks.
module scroll_rate_div
  import scroll_pkg::*;
#(
  parameter int SPEED_LVLS = SPEED_LVLS_DEF,
  parameter int SPD_W      = $clog2(SPEED_LVLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             count_en,
  input  logic             pulse_speed,
  output logic             div_hit,
  output logic [SPD_W-1:0] speed
);

  localparam int DIV_W = SPEED_LVLS - 1;

  logic [DIV_W-1:0] div_q, div_d, lim;
  logic [SPD_W-1:0] speed_q, speed_d;

  // 2^(L-1-s)-1 is simply the all-ones slowest limit shifted right by s.
  assign lim     = {DIV_W{1'b1}} >> speed_q;
  assign div_hit = count_en & tick_in & (div_q == lim);
  assign speed   = speed_q;

  always_comb begin
    div_d   = div_q;
    speed_d = speed_q;
    if (pulse_speed) begin
      speed_d = (speed_q == SPD_W'(SPEED_LVLS - 1)) ? '0 : speed_q + SPD_W'(1);
      div_d   = '0;
    end else if (count_en && tick_in) begin
      div_d = div_hit ? '0 : div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      speed_q <= '0;
    end else begin
      div_q   <= div_d;
      speed_q <= speed_d;
    end
  end

endmodule

// File: rtl/scroll_ctrl_fsm.sv
// Scroll controller: RUN/STOP/STEP FSM, position counter, direction and glitch-free message switch.
// Define AUTO_STOP_EN for one-shot mode (a wrap produced in RUN drops the FSM into STOP).
module scroll_ctrl_fsm
  import scroll_pkg::*;
#(
  parameter int NUM_MSG    = NUM_MSG_DEF,
  parameter int MSG_LEN    = MSG_LEN_DEF,
  parameter int SPEED_LVLS = SPEED_LVLS_DEF,
  parameter int MSG_W      = $clog2(NUM_MSG),
  parameter int POS_W      = $clog2(MSG_LEN),
  parameter int SPD_W      = $clog2(SPEED_LVLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             pulse_pause,
  input  logic             pulse_step,
  input  logic             pulse_dir,
  input  logic             pulse_speed,
  input  logic [MSG_W-1:0] msg_req,
  output logic             adv,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic [SPD_W-1:0] speed,
  output logic [MSG_W-1:0] msg_sel,
  output logic             running,
  output logic             wrap
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(MSG_LEN - 1);

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [MSG_W-1:0] msg_sel_q, msg_sel_d, pend_q, pend_d;
  logic             adv_q, adv_d, wrap_q, wrap_d;
  logic             div_hit, at_edge, msg_ok;

  scroll_rate_div #(
    .SPEED_LVLS (SPEED_LVLS),
    .SPD_W      (SPD_W)
  ) u_rate_div (
    .clk         (clk),
    .rst         (rst),
    .tick_in     (tick_in),
    .count_en    (state_q == ST_RUN),
    .pulse_speed (pulse_speed),
    .div_hit     (div_hit),
    .speed       (speed)
  );

  assign msg_ok  = int'(msg_req) < NUM_MSG;
  assign at_edge = dir_q ? (pos_q == '0) : (pos_q == POS_MAX);

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dir_d     = dir_q ^ pulse_dir;
    msg_sel_d = msg_sel_q;
    // pend tracks the latest legal request; matching msg_sel means nothing pending.
    pend_d    = msg_ok ? msg_req : pend_q;
    adv_d     = ((state_q == ST_RUN) && div_hit) || (state_q == ST_STEP);
    wrap_d    = adv_d && at_edge;

    if (adv_d) begin
      if (dir_q) pos_d = at_edge ? POS_MAX : pos_q - POS_W'(1);
      else       pos_d = at_edge ? '0 : pos_q + POS_W'(1);
    end
    if (wrap_d) msg_sel_d = pend_d;
    if ((state_q == ST_STOP) && (pend_d != msg_sel_q)) begin
      msg_sel_d = pend_d;
      pos_d     = '0;
    end

    case (state_q)
      ST_RUN: begin
        if (pulse_pause) state_d = ST_STOP;
`ifdef AUTO_STOP_EN
        else if (wrap_d) state_d = ST_STOP;
`endif
      end
      ST_STOP: begin
        if (pulse_pause)     state_d = ST_RUN;
        else if (pulse_step) state_d = ST_STEP;
      end
      ST_STEP: state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      msg_sel_q <= '0;
      pend_q    <= '0;
      adv_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      msg_sel_q <= msg_sel_d;
      pend_q    <= pend_d;
      adv_q     <= adv_d;
      wrap_q    <= wrap_d;
    end
  end

  assign adv     = adv_q;
  assign wrap    = wrap_q;
  assign pos     = pos_q;
  assign dir     = dir_q;
  assign msg_sel = msg_sel_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: doc/scroll_ctrl_fsm.md
Name: scroll_ctrl_fsm

Overview:
Parametrised scroll controller for the sliding-text display. It extends the basic run/stop toggle with:
- single-step
- direction reversal
- selectable scroll speed
- glitch-free multi-message selection

It owns the character position counter and sits between the input conditioning (debouncers, edge detectors, tick prescaler) and the message ROM mux and display shifter.

Parameters:
NUM_MSG, 4, number of selectable messages (>=2)
MSG_LEN, 16, character positions per message (>=2)
SPEED_LVLS, 4, number of speed levels (>=2); level k advances once every 2^(SPEED_LVLS-1-k) ticks
MSG_W, $clog2(NUM_MSG), derived width of message index
POS_W, $clog2(MSG_LEN), derived width of position
SPD_W, $clog2(SPEED_LVLS), derived width of speed index

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tick_in  in  1  one-cycle base scroll tick from prescaler
pulse_pause  in  1  one-cycle pulse; toggles RUN/STOP
pulse_step  in  1  one-cycle pulse; single advance while stopped
pulse_dir  in  1  one-cycle pulse; toggles direction
pulse_speed  in  1  one-cycle pulse; cycles speed level
msg_req  in  MSG_W  debounced requested message index
adv  out  1  registered one-cycle advance strobe
pos  out  POS_W  current character offset
dir  out  1  0 = left (increment), 1 = right (decrement)
speed  out  SPD_W  current speed level
msg_sel  out  MSG_W  message index driving the ROM mux
running  out  1  high only in RUN
wrap  out  1  registered one-cycle pulse on position wrap

Behaviour:
- Reset values: state RUN, pos 0, dir 0, speed 0 (slowest), msg_sel 0, divider 0, adv 0, wrap 0, running 1.
- States: RUN, STOP, STEP.
  - RUN: pulse_pause -> STOP.
  - STOP: pulse_pause -> RUN; else pulse_step -> STEP.
  - STEP: unconditionally -> STOP after one cycle.
- Pause has priority over step. When both pulses arrive in STOP, go to RUN and drop the step. pulse_step in RUN or STEP is ignored.
- Divider in RUN:
  - Counts tick_in pulses.
  - On the tick where the count equals 2^(SPEED_LVLS-1-speed)-1, clear the count and issue an advance.
  - The divider holds its value in STOP and STEP.
- STEP issues exactly one advance and does not touch the divider.
- Advance timing: adv is asserted the clock after the qualifying tick or STEP entry. pos updates on the same edge that raises adv.
- Position update:
  - dir 0: pos+1, wrapping MSG_LEN-1 -> 0.
  - dir 1: pos-1, wrapping 0 -> MSG_LEN-1.
  - A wrap is any advance that crosses the 0 / MSG_LEN-1 boundary. wrap pulses coincident with that adv.
- pulse_dir: toggles dir at the next edge in any state. An advance issued in the same cycle uses the old dir.
- pulse_speed: speed <= speed+1, wrapping SPEED_LVLS-1 -> 0, and clears the divider.
  - For non-power-of-2 SPEED_LVLS, wrap at SPEED_LVLS-1.
- Message switch (msg_req != msg_sel):
  - In STOP: msg_sel <= msg_req and pos <= 0 at the next edge.
  - In RUN/STEP: the request is pending until the next wrap. On that wrap, msg_sel <= msg_req, and pos takes its normal wrapped value.
  - The latest msg_req wins. A request that returns to msg_sel before a wrap cancels the switch.
- msg_req >= NUM_MSG is ignored; msg_sel is held.
- Reset mid-operation: all registers return to their reset values immediately and asynchronously. Any pending switch is discarded.

Optional Feature:
Macro AUTO_STOP_EN enables one-shot display mode.
- Defined: every wrap produced in RUN also moves the state to STOP at the same edge; running drops with the wrap pulse. A wrap produced by STEP has no extra effect.
- Undefined: a wrap never changes state.
- Port list is identical in both builds.

Decomposition:
- Shared package scroll_pkg holds the state encoding (STOP/RUN/STEP) and the default parameter constants.
- One sub-module is natural: scroll_rate_div, containing the tick divider and the speed register.
- The FSM, position counter and message-switch logic stay in the top module.

Test Plan:
- Reset, then 8 tick_in at speed 0 with SPEED_LVLS=4: adv every 8th tick, pos=1 after 8 ticks, running=1, msg_sel=0.
- pulse_pause, then 3 pulse_step with ticks ongoing: pos advances exactly 3, adv is 3 single-cycle pulses, the divider is frozen; then pause and step in the same cycle -> RUN with no step.
- At pos=0, pulse_dir then one advance: pos=15 and wrap=1 in the same cycle; a pulse_dir coincident with adv uses the old direction.
- In RUN at pos=5, msg_req=2: msg_sel stays 0 until the advance from 15 -> 0, then msg_sel=2 on the wrap edge; in STOP, msg_req=3 gives msg_sel=3 and pos=0 the next cycle.
- pulse_speed x4 from reset: speed goes 1,2,3,0; at speed 3 adv occurs on every tick; the divider clears on each change.
- With AUTO_STOP_EN, running from pos=14 for 2 advances: wrap pulses, state is STOP and running=0; further ticks give no adv.
